// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (IFU, LSU) arbiter in front of one memory port.
// Each transaction runs IDLE -> REQ -> WAIT -> IDLE, with only one in flight.
// Request fields are captured when the winner is chosen. They stay stable
// while the memory stalls.
// Optional build macro: YSYX_23060251_ARB_RR_EN selects round-robin on
// contention. The default build uses fixed LSU-over-IFU priority.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic            clk_i,
  input  logic            rst_i,
  // fetch requester
  input  logic            ifu_req_valid_i,
  output logic            ifu_req_ready_o,
  input  logic [AW-1:0]   ifu_addr_i,
  output logic            ifu_rsp_valid_o,
  // load/store requester
  input  logic            lsu_req_valid_i,
  output logic            lsu_req_ready_o,
  input  logic [AW-1:0]   lsu_addr_i,
  input  logic            lsu_wen_i,
  input  logic [DW-1:0]   lsu_wdata_i,
  input  logic [DW/8-1:0] lsu_wmask_i,
  output logic            lsu_rsp_valid_o,
  // shared response data
  output logic [DW-1:0]   rsp_rdata_o,
  // downstream memory port
  output logic            mem_req_valid_o,
  input  logic            mem_req_ready_i,
  output logic [AW-1:0]   mem_addr_o,
  output logic            mem_wen_o,
  output logic [DW-1:0]   mem_wdata_o,
  output logic [DW/8-1:0] mem_wmask_o,
  input  logic            mem_rsp_valid_i,
  input  logic [DW-1:0]   mem_rdata_i,
  output logic [1:0]      grant_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e          state_q, state_d;
  // grant_q doubles as the owner register: {lsu, ifu}, zero when idle
  logic [1:0]      grant_q, grant_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wen_q, wen_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW/8-1:0] wmask_q, wmask_d;
  logic            win_lsu_s;
  logic            live_s;

`ifdef YSYX_23060251_ARB_RR_EN
  // 1 means the LSU wins the next contention; reset favours the IFU
  logic            prio_lsu_q, prio_lsu_d;

  // Round-robin winner selection: on contention, pick the side not granted last
  always_comb begin
    win_lsu_s = lsu_req_valid_i && (!ifu_req_valid_i || prio_lsu_q);
  end
`else
  // Fixed-priority winner selection: the LSU beats the IFU whenever it is valid
  always_comb begin
    win_lsu_s = lsu_req_valid_i;
  end
`endif

  // Next-state, owner and captured request fields for the transaction FSM
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
`ifdef YSYX_23060251_ARB_RR_EN
    prio_lsu_d = prio_lsu_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ifu_req_valid_i || lsu_req_valid_i) begin
          state_d = ST_REQ;
          if (win_lsu_s) begin
            grant_d = 2'b10;
            addr_d  = lsu_addr_i;
            wen_d   = lsu_wen_i;
            wdata_d = lsu_wdata_i;
            wmask_d = lsu_wmask_i;
          end else begin
            // fetches are always reads with an empty mask
            grant_d = 2'b01;
            addr_d  = ifu_addr_i;
            wen_d   = 1'b0;
            wdata_d = {DW{1'b0}};
            wmask_d = {(DW/8){1'b0}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_req_ready_i) begin
          state_d = ST_WAIT;
`ifdef YSYX_23060251_ARB_RR_EN
          // favour the side that was not just granted
          prio_lsu_d = grant_q[0];
`endif
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid_i) begin
          state_d = ST_IDLE;
          grant_d = 2'b00;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  // FSM and captured-field registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      grant_q    <= 2'b00;
      addr_q     <= {AW{1'b0}};
      wen_q      <= 1'b0;
      wdata_q    <= {DW{1'b0}};
      wmask_q    <= {(DW/8){1'b0}};
`ifdef YSYX_23060251_ARB_RR_EN
      prio_lsu_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
`ifdef YSYX_23060251_ARB_RR_EN
      prio_lsu_q <= prio_lsu_d;
`endif
    end
  end

  // Handshake outputs. They are gated by reset so that nothing leaks out
  // during the reset cycle itself.
  always_comb begin
    live_s          = !rst_i;
    mem_req_valid_o = live_s && (state_q == ST_REQ);
    ifu_req_ready_o = mem_req_valid_o && grant_q[0] && mem_req_ready_i;
    lsu_req_ready_o = mem_req_valid_o && grant_q[1] && mem_req_ready_i;
    ifu_rsp_valid_o = live_s && (state_q == ST_WAIT) && grant_q[0] && mem_rsp_valid_i;
    lsu_rsp_valid_o = live_s && (state_q == ST_WAIT) && grant_q[1] && mem_rsp_valid_i;
    grant_o         = live_s ? grant_q : 2'b00;
    rsp_rdata_o     = mem_rdata_i;
    mem_addr_o      = addr_q;
    mem_wen_o       = wen_q;
    mem_wdata_o     = wdata_q;
    mem_wmask_o     = wmask_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change 1 time unit after the rising
// edge, and outputs are sampled 1 time unit after that.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 64;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic            ifu_req_valid_i = 1'b0;
  logic            ifu_req_ready_o;
  logic [AW-1:0]   ifu_addr_i = '0;
  logic            ifu_rsp_valid_o;
  logic            lsu_req_valid_i = 1'b0;
  logic            lsu_req_ready_o;
  logic [AW-1:0]   lsu_addr_i = '0;
  logic            lsu_wen_i = 1'b0;
  logic [DW-1:0]   lsu_wdata_i = '0;
  logic [DW/8-1:0] lsu_wmask_i = '0;
  logic            lsu_rsp_valid_o;
  logic [DW-1:0]   rsp_rdata_o;
  logic            mem_req_valid_o;
  logic            mem_req_ready_i = 1'b0;
  logic [AW-1:0]   mem_addr_o;
  logic            mem_wen_o;
  logic [DW-1:0]   mem_wdata_o;
  logic [DW/8-1:0] mem_wmask_o;
  logic            mem_rsp_valid_i = 1'b0;
  logic [DW-1:0]   mem_rdata_i = '0;
  logic [1:0]      grant_o;

  int checks_cnt = 0;
  int fail_cnt   = 0;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o),
    .ifu_addr_i(ifu_addr_i), .ifu_rsp_valid_o(ifu_rsp_valid_o),
    .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o),
    .lsu_addr_i(lsu_addr_i), .lsu_wen_i(lsu_wen_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_wmask_i(lsu_wmask_i), .lsu_rsp_valid_o(lsu_rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o(mem_addr_o), .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o),
    .mem_wmask_o(mem_wmask_o), .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rdata_i(mem_rdata_i), .grant_o(grant_o)
  );

  // Free-running clock, period 10
  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle: inputs may be changed right after this returns
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Runs one transaction starting from an IDLE cycle where the requests are
  // already driven. drop_winner releases the winner's valid after its handshake.
  task automatic serve(input string tag, input logic [1:0] exp_grant,
                       input logic [31:0] exp_addr, input logic [63:0] rdata,
                       input logic drop_winner);
    tick();                         // REQ
    mem_req_ready_i = 1'b1;
    #1;
    check_val({tag, "_grant"}, grant_o, exp_grant);
    check_val({tag, "_addr"}, mem_addr_o, exp_addr);
    check_val({tag, "_ifu_rdy"}, ifu_req_ready_o, exp_grant[0]);
    check_val({tag, "_lsu_rdy"}, lsu_req_ready_o, exp_grant[1]);
    tick();                         // WAIT
    mem_req_ready_i = 1'b0;
    if (drop_winner && exp_grant[1]) lsu_req_valid_i = 1'b0;
    if (drop_winner && exp_grant[0]) ifu_req_valid_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rdata_i = rdata;
    #1;
    check_val({tag, "_ifu_rsp"}, ifu_rsp_valid_o, exp_grant[0]);
    check_val({tag, "_lsu_rsp"}, lsu_rsp_valid_o, exp_grant[1]);
    check_val({tag, "_rdata"}, rsp_rdata_o, rdata);
    tick();                         // IDLE
    mem_rsp_valid_i = 1'b0;
    #1;
    check_val({tag, "_idle_grant"}, grant_o, 2'b00);
  endtask

  // Directed scenarios
  initial begin
    logic [1:0] rr_exp [4];
    // reset state
    tick();
    tick();
    check_val("rst_grant", grant_o, 2'b00);
    check_val("rst_memv", mem_req_valid_o, 1'b0);
    rst_i = 1'b0;

    // IFU-only fetch with hand-checked cycle timing
    ifu_req_valid_i = 1'b1;
    ifu_addr_i = 32'h8000_0000;
    #1;
    check_val("f_c0_grant", grant_o, 2'b00);
    check_val("f_c0_memv", mem_req_valid_o, 1'b0);
    tick();
    mem_req_ready_i = 1'b1;
    #1;
    check_val("f_c1_memv", mem_req_valid_o, 1'b1);
    check_val("f_c1_addr", mem_addr_o, 32'h8000_0000);
    check_val("f_c1_wen", mem_wen_o, 1'b0);
    check_val("f_c1_wmask", mem_wmask_o, 8'h00);
    check_val("f_c1_ifu_rdy", ifu_req_ready_o, 1'b1);
    check_val("f_c1_lsu_rdy", lsu_req_ready_o, 1'b0);
    check_val("f_c1_grant", grant_o, 2'b01);
    tick();
    ifu_req_valid_i = 1'b0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rdata_i = 64'h13;
    #1;
    check_val("f_c2_ifu_rsp", ifu_rsp_valid_o, 1'b1);
    check_val("f_c2_rdata", rsp_rdata_o, 64'h13);
    check_val("f_c2_lsu_rsp", lsu_rsp_valid_o, 1'b0);
    check_val("f_c2_memv", mem_req_valid_o, 1'b0);
    tick();
    mem_rsp_valid_i = 1'b0;
    #1;
    check_val("f_c3_grant", grant_o, 2'b00);
    check_val("f_c3_ifu_rsp", ifu_rsp_valid_o, 1'b0);

    // stray response in IDLE is ignored
    mem_rsp_valid_i = 1'b1;
    #1;
    check_val("idle_stray_ifu", ifu_rsp_valid_o, 1'b0);
    check_val("idle_stray_lsu", lsu_rsp_valid_o, 1'b0);
    tick();
    mem_rsp_valid_i = 1'b0;
    #1;
    check_val("idle_stray_grant", grant_o, 2'b00);

    // simultaneous requests: LSU first, then IFU
    lsu_req_valid_i = 1'b1;
    lsu_addr_i = 32'h0000_0100;
    ifu_req_valid_i = 1'b1;
    ifu_addr_i = 32'h0000_0200;
    serve("both_lsu", 2'b10, 32'h0000_0100, 64'hAA, 1'b1);
    serve("both_ifu", 2'b01, 32'h0000_0200, 64'hBB, 1'b1);

    // LSU store with a memory stall of three cycles
    lsu_req_valid_i = 1'b1;
    lsu_addr_i = 32'h0000_0300;
    lsu_wen_i = 1'b1;
    lsu_wdata_i = 64'hDEAD_BEEF;
    lsu_wmask_i = 8'h0F;
    tick();                         // REQ
    for (int i = 0; i < 4; i++) begin
      mem_req_ready_i = (i == 3);
      mem_rsp_valid_i = (i == 0);   // stray response in REQ
      #1;
      check_val($sformatf("st_addr%0d", i), mem_addr_o, 32'h0000_0300);
      check_val($sformatf("st_wen%0d", i), mem_wen_o, 1'b1);
      check_val($sformatf("st_wdata%0d", i), mem_wdata_o, 64'hDEAD_BEEF);
      check_val($sformatf("st_wmask%0d", i), mem_wmask_o, 8'h0F);
      check_val($sformatf("st_memv%0d", i), mem_req_valid_o, 1'b1);
      check_val($sformatf("st_rdy%0d", i), lsu_req_ready_o, (i == 3));
      check_val($sformatf("st_rsp%0d", i), lsu_rsp_valid_o, 1'b0);
      tick();
    end
    // now in WAIT
    lsu_req_valid_i = 1'b0;
    lsu_wen_i = 1'b0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b1;
    mem_rdata_i = 64'h0;
    #1;
    check_val("st_rdy_after", lsu_req_ready_o, 1'b0);
    check_val("st_rsp", lsu_rsp_valid_o, 1'b1);
    tick();
    mem_rsp_valid_i = 1'b0;

    // reset while waiting for a response, then a late response
    ifu_req_valid_i = 1'b1;
    ifu_addr_i = 32'h0000_0400;
    tick();                         // REQ
    mem_req_ready_i = 1'b1;
    tick();                         // WAIT
    mem_req_ready_i = 1'b0;
    ifu_req_valid_i = 1'b0;
    #1;
    check_val("rw_grant_wait", grant_o, 2'b01);
    rst_i = 1'b1;
    mem_rsp_valid_i = 1'b1;
    #1;
    check_val("rw_rst_rsp", ifu_rsp_valid_o, 1'b0);
    check_val("rw_rst_grant", grant_o, 2'b00);
    tick();
    rst_i = 1'b0;
    #1;
    check_val("rw_late_rsp", ifu_rsp_valid_o, 1'b0);
    check_val("rw_late_lsu", lsu_rsp_valid_o, 1'b0);
    check_val("rw_grant", grant_o, 2'b00);
    check_val("rw_memv", mem_req_valid_o, 1'b0);
    tick();
    mem_rsp_valid_i = 1'b0;
    #1;
    check_val("rw_still_idle", grant_o, 2'b00);

    // continuous contention for four transactions, starting just after reset
`ifdef YSYX_23060251_ARB_RR_EN
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
`else
    rr_exp[0] = 2'b10; rr_exp[1] = 2'b10; rr_exp[2] = 2'b10; rr_exp[3] = 2'b10;
`endif
    lsu_req_valid_i = 1'b1;
    lsu_addr_i = 32'h0000_0100;
    ifu_req_valid_i = 1'b1;
    ifu_addr_i = 32'h0000_0200;
    for (int t = 0; t < 4; t++) begin
      serve($sformatf("cont%0d", t), rr_exp[t],
            rr_exp[t][1] ? 32'h0000_0100 : 32'h0000_0200, 64'h1000 + t, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

  // Guard against a stuck simulation
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
